// File: rtl/rabbit_ks_xor_if.sv
// Valid/ready word stream with an end-of-message marker.
interface rabbit_ks_xor_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/rabbit_ks_xor.sv
// Buffers one 128-bit Rabbit keystream block and XORs it slice by slice onto a word stream.
// The generator is advanced (ks_en_o) exactly once per block pulled into the buffer.
module rabbit_ks_xor #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ks_ready_i,
    input  logic [127:0]           keystream_i,
    output logic                   ks_en_o,
    input  logic                   flush_i,
    rabbit_ks_xor_if.slave         in_if,
    rabbit_ks_xor_if.master        out_if,
    output logic [15:0]            blk_cnt_o
);
    localparam int unsigned WORDS = 128 / DATA_W;
    localparam int unsigned IdxW  = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e                       state_q, state_d;
    logic [WORDS-1:0][DATA_W-1:0] buf_q, buf_d;
    logic [IdxW-1:0]              idx_q, idx_d;
    logic                         out_valid_q, out_valid_d;
    logic [DATA_W-1:0]            out_data_q, out_data_d;
    logic                         out_last_q, out_last_d;
    logic [15:0]                  blk_cnt_q, blk_cnt_d;

    logic in_ready;
    logic acc;
    logic blk_end;
    logic load;

    // Handshake and load strobe; load is masked in reset and flush so the generator never steps.
    always_comb begin
        in_ready = (state_q == StFull) && (!out_valid_q || out_if.ready);
        acc      = in_if.valid && in_ready;
        blk_end  = (idx_q == IdxW'(WORDS - 1)) || in_if.last;
        load     = rst_n && !flush_i && ks_ready_i &&
                   ((state_q == StEmpty) || (acc && blk_end));
    end

    // Next-state: flush wins; a load in the same cycle as the final accept refills without a bubble.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        blk_cnt_d   = blk_cnt_q;
        if (flush_i) begin
            state_d     = StEmpty;
            idx_d       = '0;
            out_valid_d = 1'b0;
            blk_cnt_d   = '0;
        end else begin
            if (acc) begin
                out_data_d  = in_if.data ^ buf_q[idx_q];
                out_last_d  = in_if.last;
                out_valid_d = 1'b1;
                idx_d       = idx_q + IdxW'(1);
                // Leftover slices after in_last are dropped; the next message gets a fresh block.
                if (blk_end) begin
                    state_d = StEmpty;
                end
            end else if (out_if.ready) begin
                out_valid_d = 1'b0;
            end
            if (load) begin
                buf_d     = keystream_i;
                idx_d     = '0;
                state_d   = StFull;
                blk_cnt_d = blk_cnt_q + 16'd1;
            end
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            buf_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    // Output drive.
    always_comb begin
        ks_en_o      = load;
        in_if.ready  = in_ready;
        out_if.valid = out_valid_q;
        out_if.data  = out_data_q;
        out_if.last  = out_last_q;
        blk_cnt_o    = blk_cnt_q;
    end
endmodule

// File: tb/tb_rabbit_ks_xor.sv
// Bench for rabbit_ks_xor: generator model, negedge scoreboard, vector table and corner sequences.
module tb_rabbit_ks_xor;
    localparam int unsigned DATA_W = 32;
    localparam logic [127:0] K0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ks_ready = 1'b0;
    logic         flush = 1'b0;
    logic         ks_en;
    logic [127:0] keystream;
    logic [15:0]  blk_cnt;

    rabbit_ks_xor_if #(.DATA_W(DATA_W)) in_if ();
    rabbit_ks_xor_if #(.DATA_W(DATA_W)) out_if ();

    rabbit_ks_xor #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ks_ready_i  (ks_ready),
        .keystream_i (keystream),
        .ks_en_o     (ks_en),
        .flush_i     (flush),
        .in_if       (in_if),
        .out_if      (out_if),
        .blk_cnt_o   (blk_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Generator model: block 0 is the reference pattern, later blocks have distinct words.
    function automatic logic [127:0] ks_of(input int unsigned n);
        logic [127:0] k;
        if (n == 0) return K0;
        for (int w = 0; w < 4; w++) begin
            k[32*w +: 32] = 32'hC0DE_0000 | ((n & 32'hFFF) << 4) | w;
        end
        return k;
    endfunction

    int unsigned gen_n = 0;
    always @(posedge clk) if (ks_en) gen_n <= gen_n + 1;
    assign keystream = ks_of(gen_n);

    // Scoreboard, sampled mid-cycle.
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t         exp_q[$];
    logic [31:0]  cap_data[$];
    int           cap_cyc[$];
    int           cyc = 0;
    int           ks_en_cnt = 0;
    int unsigned  cur_blk = 0;
    int           cur_word = 0;
    exp_t         e;
    logic [127:0] kblk;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n || flush) begin
            exp_q.delete();
            cur_blk  = gen_n;
            cur_word = 0;
        end else begin
            if (ks_en) ks_en_cnt++;
            if (out_if.valid && out_if.ready) begin
                cap_data.push_back(out_if.data);
                cap_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %0h expected none", out_if.data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", out_if.data, e.data);
                    check("sb_last", out_if.last, e.last);
                end
            end
            if (in_if.valid && in_if.ready) begin
                kblk = ks_of(cur_blk);
                exp_q.push_back({in_if.data ^ kblk[32*cur_word +: 32], in_if.last});
                cur_word++;
                if (in_if.last || cur_word == 4) begin
                    cur_blk++;
                    cur_word = 0;
                end
            end
        end
    end

    // Present one word and hold it until accepted (bounded).
    task automatic send(input logic [31:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        in_if.valid = 1'b1;
        in_if.data  = d;
        in_if.last  = l;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_if.ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got no in_ready expected in_ready for %0h", d);
        end
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t tab[8];
        int   b, en0;
        tab[0] = '{32'h0000_0000, 1'b0, 32'hCCDD_EEFF};
        tab[1] = '{32'h0000_0000, 1'b0, 32'h8899_AABB};
        tab[2] = '{32'h0000_0000, 1'b0, 32'h4455_6677};
        tab[3] = '{32'h0000_0000, 1'b0, 32'h0011_2233};
        tab[4] = '{32'hFFFF_FFFF, 1'b0, 32'h3F21_FFEF};
        tab[5] = '{32'h1234_5678, 1'b0, 32'hD2EA_5669};
        tab[6] = '{32'h0000_FFFF, 1'b0, 32'hC0DE_FFED};
        tab[7] = '{32'hA5A5_A5A5, 1'b1, 32'h657B_A5B6};

        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.last   = 1'b0;
        out_if.ready = 1'b1;
        ks_ready     = 1'b1;

        // Reset state, with ks_ready high to show ks_en is held low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_if.valid, 0);
        check("rst_out_data", out_if.data, 0);
        check("rst_out_last", out_if.last, 0);
        check("rst_blk_cnt", blk_cnt, 0);
        check("rst_ks_en", ks_en, 0);
        check("rst_in_ready", in_if.ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Slice order and back-to-back blocks K0, K1.
        b   = cap_data.size();
        en0 = ks_en_cnt;
        for (int i = 0; i < 8; i++) send(tab[i].data, tab[i].last);
        idle(3);
        if (cap_data.size() < b + 8) begin
            n_tests++;
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 8", cap_data.size() - b);
        end else begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("vec%0d_data", i), cap_data[b+i], tab[i].exp);
                check($sformatf("vec%0d_gap", i), cap_cyc[b+i] - cap_cyc[b], i);
            end
        end
        check("b2b_ks_en_pulses", ks_en_cnt - en0, 3);
        check("b2b_blk_cnt", blk_cnt, 3);

        // Early in_last: next message starts on slice 0 of a new block.
        b   = cap_data.size();
        en0 = ks_en_cnt;
        send(32'h1111_1111, 1'b0);
        send(32'h2222_2222, 1'b1);
        send(32'h3333_3333, 1'b1);
        idle(3);
        if (cap_data.size() < b + 3) begin
            n_tests++;
            n_fail++;
            $display("FAIL early_count: got %0d expected 3", cap_data.size() - b);
        end else begin
            check("early_w1", cap_data[b+1], 32'hE2FC_2203);
            check("early_new_msg", cap_data[b+2], 32'hF3ED_3303);
        end
        check("early_ks_en_pulses", ks_en_cnt - en0, 2);
        check("early_blk_cnt", blk_cnt, 5);

        // Backpressure: output held, input stalled, resumes in order.
        b = cap_data.size();
        out_if.ready = 1'b0;
        send(32'hA0A0_A0A0, 1'b0);
        in_if.valid = 1'b1;
        in_if.data  = 32'hB0B0_B0B0;
        in_if.last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_if.valid, 1);
            check("bp_out_data", out_if.data, 32'h607E_A0E0);
            check("bp_in_ready", in_if.ready, 0);
        end
        @(posedge clk);
        #1;
        out_if.ready = 1'b1;
        send(32'hB0B0_B0B0, 1'b1);
        idle(3);
        check("bp_out_count", cap_data.size() - b, 2);
        check("bp_blk_cnt", blk_cnt, 6);

        // Starvation after reset: nothing moves until ks_ready rises.
        rst_n       = 1'b0;
        ks_ready    = 1'b0;
        in_if.valid = 1'b1;
        in_if.data  = 32'hC0C0_C0C0;
        in_if.last  = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("starve_in_ready", in_if.ready, 0);
            check("starve_ks_en", ks_en, 0);
            check("starve_out_valid", out_if.valid, 0);
        end
        @(posedge clk);
        #1;
        ks_ready = 1'b1;
        @(negedge clk);
        check("starve_rise_ks_en", ks_en, 1);
        check("starve_rise_in_ready", in_if.ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("starve_next_in_ready", in_if.ready, 1);
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        idle(3);

        // Flush after two words, with an accept+refill that flush must override.
        send(32'hD0D0_D0D0, 1'b0);
        send(32'hD1D1_D1D1, 1'b0);
        flush       = 1'b1;
        in_if.valid = 1'b1;
        in_if.data  = 32'hDEAD_BEEF;
        in_if.last  = 1'b1;
        @(negedge clk);
        check("flush_ks_en", ks_en, 0);
        @(posedge clk);
        #1;
        flush       = 1'b0;
        in_if.valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_if.valid, 0);
        check("flush_blk_cnt", blk_cnt, 0);
        @(posedge clk);
        #1;
        b = cap_data.size();
        send(32'hE0E0_E0E0, 1'b1);
        idle(3);
        if (cap_data.size() < b + 1) begin
            n_tests++;
            n_fail++;
            $display("FAIL flush_count: got %0d expected 1", cap_data.size() - b);
        end else begin
            check("flush_fresh_slice0", cap_data[b], 32'h203E_E060);
        end
        check("flush_blk_cnt_after", blk_cnt, 2);
        check("sb_drained", exp_q.size(), 0);

        // Asynchronous reset mid-transfer with an output pending.
        out_if.ready = 1'b0;
        send(32'hF0F0_F0F0, 1'b1);
        #2;
        check("pre_rst_out_valid", out_if.valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_if.valid, 0);
        check("arst_out_data", out_if.data, 0);
        check("arst_out_last", out_if.last, 0);
        check("arst_blk_cnt", blk_cnt, 0);
        check("arst_ks_en", ks_en, 0);
        check("arst_in_ready", in_if.ready, 0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        out_if.ready = 1'b1;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/rabbit_ks_xor.md
Name: rabbit_ks_xor

Overview:
- Downstream consumer of the Rabbit keystream generator. Buffers one 128-bit keystream block and XORs it word by word onto a valid/ready data stream, producing ciphertext or plaintext.
- Drives the generator's `en` input so that the generator advances exactly one iteration per consumed block.
- Sits between rabbit_top (keystream/ready/en) and the system data path.

Parameters:
- DATA_W, 32, data word width. Must divide 128. Legal values: 8, 16, 32, 64.
- WORDS, 128/DATA_W, derived; number of data words per keystream block. Not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ks_ready  in  1  generator is in RUN state and keystream is valid (rabbit_top ready).
- keystream  in  128  current generator output; combinational from generator state.
- ks_en  out  1  advance-generator strobe (to rabbit_top en).
- flush  in  1  synchronous; discards the buffered block and any pending output.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts input word.
- in_data  in  DATA_W  plaintext or ciphertext word.
- in_last  in  1  final word of the message.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts output word.
- out_data  out  DATA_W  in_data XOR keystream slice.
- out_last  out  1  copy of in_last for this word.
- blk_cnt  out  16  keystream blocks consumed since reset or flush; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (rst_n=0, asynchronous) clears all of the following:
  - state=EMPTY, idx=0, buffer=0;
  - out_valid=0, out_data=0, out_last=0;
  - blk_cnt=0, ks_en=0, in_ready=0.
- A reset mid-message drops all buffered data with no output.
- States:
  - EMPTY: no keystream buffered.
  - FULL: buffer holds a block; idx (log2 WORDS bits) selects the next slice.
- Load strobe: load = ks_ready && (state==EMPTY || (acc && (idx==WORDS-1 || in_last))).
  - acc = in_valid && in_ready.
  - ks_en = load, combinational, one cycle per load.
  - On load: buffer <= keystream, idx <= 0, state <= FULL, blk_cnt <= blk_cnt+1.
  - The generator advances on the same edge, so each block is used exactly once.
- Refill timing: the same-cycle refill on the last word gives back-to-back blocks with no bubble.
  - If the last word is accepted while ks_ready=0, go to EMPTY.
- Slice order: word k uses buffer[DATA_W*k +: DATA_W]. Word 0 is the LSBs.
- Handshake:
  - in_ready = (state==FULL) && (!out_valid || out_ready).
  - On acc: out_data <= in_data ^ slice(idx), out_last <= in_last, out_valid <= 1, idx <= idx+1.
  - Otherwise, if out_ready, out_valid <= 0.
  - Latency: 1 cycle from accepted input to out_valid.
  - Throughput: 1 word/cycle when ks_ready is held high.
- in_last: remaining slices of the current block are discarded. The next message starts on a fresh block: refill if ks_ready, else EMPTY.
- out_data and out_last hold stable while out_valid && !out_ready.
- No input is accepted in EMPTY, even with in_valid=1.
- flush: has priority over load and acc in the same cycle.
  - state=EMPTY, out_valid=0, blk_cnt=0, ks_en=0 that cycle.
  - Used after rabbit_top is rekeyed.
- ks_ready deasserting while FULL: no effect until the next load is needed.

Test Plan:
- Block ordering: DATA_W=32, ks_ready=1, keystream=128'h00112233_44556677_8899AABB_CCDDEEFF, 4 input words of 0, out_ready=1.
  -> out_data CCDDEEFF, 8899AABB, 44556677, 00112233 on consecutive cycles.
  -> ks_en pulses once at fill, and again in the cycle the 4th word is accepted.
  -> blk_cnt=2.
- Back-to-back throughput: 8 words with in_valid held high, generator model producing blocks K0 then K1.
  -> 8 outputs on 8 consecutive cycles with no bubble; words 4-7 XOR K1 slices.
- Early in_last: in_last on word 1, then a new message.
  -> the new message's word 0 uses slice 0 of the next block; 2 ks_en pulses total.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1.
  -> out_data stable, in_ready=0, idx unchanged; flow resumes without loss or duplicates.
- Starvation: ks_ready=0 after reset with in_valid=1.
  -> in_ready=0, ks_en=0, out_valid=0.
  -> ks_ready rises: ks_en=1 that cycle, in_ready=1 the next cycle.
- Flush and reset mid-block: flush after 2 words.
  -> out_valid=0 next cycle, blk_cnt=0, next word uses slice 0 of a fresh block.
  -> rst_n low asynchronously mid-transfer: all outputs 0 immediately.
